// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared SHA-256 types, constants and sigma functions
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int ROUNDS_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam word_t H0 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// rtl/sha256_w_next.sv - combinational next schedule word from a 16-word window
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [31:0] win0_i,
    input  logic [31:0] win1_i,
    input  logic [31:0] win9_i,
    input  logic [31:0] win14_i,
    output logic [31:0] w_next_o
);

    // Window holds W[t..t+15], so this yields W[t+16]; sum wraps modulo 2^32.
    assign w_next_o = small_sigma1(win14_i) + win9_i + small_sigma0(win1_i) + win0_i;

endmodule

// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - streams W[0..ROUNDS-1] from one block via a rolling window
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_block [15:0],
    input  logic        i_start,
    output logic        o_busy,
    output logic [31:0] o_w,
    output logic [5:0]  o_t,
    output logic        o_w_valid,
    input  logic        i_ready,
    output logic        o_last,
    output logic        o_done
);

    localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

    sched_state_t state_q, state_d;
    logic [31:0]  win_q [16];
    logic [31:0]  win_d [16];
    logic [5:0]   t_q, t_d;
    logic [31:0]  w_next;

    sha256_w_next u_w_next (
        .win0_i   (win_q[0]),
        .win1_i   (win_q[1]),
        .win9_i   (win_q[9]),
        .win14_i  (win_q[14]),
        .w_next_o (w_next)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        case (state_q)
            // DONE accepts a new block exactly like IDLE for back-to-back operation.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (i_start) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = i_block[i];
                    end
                    t_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_ready) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_next;
                    t_d       = t_q + 6'd1;
                    if (t_q == T_LAST) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            win_q   <= win_d;
        end
    end

    assign o_w       = win_q[0];
    assign o_t       = t_q;
    assign o_w_valid = (state_q == ST_RUN);
    assign o_busy    = (state_q == ST_RUN);
    assign o_last    = (state_q == ST_RUN) && (t_q == T_LAST);
    assign o_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - scoreboard bench for the SHA-256 message schedule
module tb_sha256_msg_sched;

    localparam int ROUNDS = 64;

    typedef struct {
        logic [5:0]  t;
        logic [31:0] w;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_block [15:0];
    logic        i_start;
    logic        o_busy;
    logic [31:0] o_w;
    logic [5:0]  o_t;
    logic        o_w_valid;
    logic        i_ready;
    logic        o_last;
    logic        o_done;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int hs_count = 0;
    exp_t sb_q[$];
    logic [31:0] got_w [64];
    logic [31:0] cur_blk [15:0];
    logic [31:0] alt_blk [15:0];

    bit          stall_prev = 0;
    logic [31:0] stall_w;
    logic [5:0]  stall_t;
    bit          done_prev = 0;

    sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_block   (i_block),
        .i_start   (i_start),
        .o_busy    (o_busy),
        .o_w       (o_w),
        .o_t       (o_t),
        .o_w_valid (o_w_valid),
        .i_ready   (i_ready),
        .o_last    (o_last),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    task automatic push_expected();
        logic [31:0] w [64];
        exp_t e;
        for (int t = 0; t < 16; t++) w[t] = cur_blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
        for (int t = 0; t < ROUNDS; t++) begin
            e.t = 6'(t);
            e.w = w[t];
            sb_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (stall_prev) begin
                chk("stall_valid", 32'(o_w_valid), 32'd1);
                chk("stall_w", o_w, stall_w);
                chk("stall_t", 32'(o_t), 32'(stall_t));
            end
            stall_prev = o_w_valid && !i_ready;
            stall_w    = o_w;
            stall_t    = o_t;
            if (o_w_valid)
                chk("o_last", 32'(o_last), 32'(o_t == 6'(ROUNDS - 1)));
            if (o_done) begin
                if (done_prev) chk("done_width", 32'd2, 32'd1);
                done_cnt++;
            end
            done_prev = o_done;
            if (o_w_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", o_w, 32'hxxxxxxxx);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_t", 32'(o_t), 32'(e.t));
                    chk("sb_w", o_w, e.w);
                end
                got_w[o_t] = o_w;
                hs_count++;
            end
        end else begin
            stall_prev = 0;
            done_prev  = 0;
        end
    end

    // rmode 0: i_ready held high; 1: pseudo-random. inject_t >= 0 drives a start with alt_blk at that t.
    task automatic run_block(input int rmode, input int inject_t);
        int cyc;
        bit injected;
        injected = 0;
        push_expected();
        hs_count = 0;
        for (int i = 0; i < 16; i++) i_block[i] = cur_blk[i];
        i_start = 1;
        i_ready = 1;
        tick();
        i_start = 0;
        chk("first_valid", 32'(o_w_valid), 32'd1);
        chk("first_t", 32'(o_t), 32'd0);
        chk("first_w", o_w, cur_blk[0]);
        chk("first_busy", 32'(o_busy), 32'd1);
        cyc = 1;
        while (!o_done && cyc < 2000) begin
            i_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (inject_t >= 0 && !injected && o_w_valid && o_t == 6'(inject_t)) begin
                for (int i = 0; i < 16; i++) i_block[i] = alt_blk[i];
                i_start  = 1;
                injected = 1;
            end else begin
                i_start = 0;
            end
            tick();
            cyc++;
        end
        i_start = 0;
        chk("done_seen", 32'(o_done), 32'd1);
        chk("done_busy", 32'(o_busy), 32'd0);
        if (rmode == 0) chk("done_latency", 32'(cyc), 32'(ROUNDS + 1));
        chk("handshakes", 32'(hs_count), 32'(ROUNDS));
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic load_abc();
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        cur_blk[0]  = 32'h61626380;
        cur_blk[15] = 32'h00000018;
    endtask

    task automatic load_ones();
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'hFFFFFFFF;
    endtask

    initial begin
        int d0;
        int cyc;
        rst     = 1'b0;
        i_start = 1'b0;
        i_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i_block[i] = 32'h0;
            alt_blk[i] = 32'hA5A50000 + 32'(i * 7 + 1);
        end
        tick();
        tick();
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_w", o_w, 32'd0);
        chk("rst_t", 32'(o_t), 32'd0);
        chk("rst_valid", 32'(o_w_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        rst = 1'b1;
        tick();

        load_abc();
        d0 = done_cnt;
        run_block(0, -1);
        tick();
        chk("abc_done_once", 32'(done_cnt), 32'(d0 + 1));
        chk("abc_w0", got_w[0], 32'h61626380);
        chk("abc_w15", got_w[15], 32'h00000018);
        chk("abc_w16", got_w[16], 32'h61626380);
        chk("abc_w17", got_w[17], 32'h000F0000);

        load_ones();
        run_block(0, -1);
        tick();
        chk("ones_w16", got_w[16], 32'h203FFFFC);

        load_abc();
        run_block(1, -1);
        tick();

        run_block(0, 10);
        tick();

        run_block(0, -1);
        load_ones();
        run_block(0, -1);
        tick();

        load_abc();
        push_expected();
        for (int i = 0; i < 16; i++) i_block[i] = cur_blk[i];
        i_start = 1;
        i_ready = 1;
        tick();
        i_start = 0;
        cyc = 0;
        while (o_t != 6'd30 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("reach_t30", 32'(o_t), 32'd30);
        #2;
        rst = 1'b0;
        #1;
        sb_q.delete();
        d0 = done_cnt;
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_w", o_w, 32'd0);
        chk("mid_rst_t", 32'(o_t), 32'd0);
        chk("mid_rst_valid", 32'(o_w_valid), 32'd0);
        chk("mid_rst_last", 32'(o_last), 32'd0);
        chk("mid_rst_done", 32'(o_done), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_no_done", 32'(done_cnt), 32'(d0));
        chk("post_rst_idle_busy", 32'(o_busy), 32'd0);
        chk("post_rst_idle_valid", 32'(o_w_valid), 32'd0);
        run_block(0, -1);
        tick();
        chk("restart_w16", got_w[16], 32'h61626380);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
